// File: rtl/spu_ibr_pkg.sv
// Shared definitions for the SPU inbound response arbiter: response field
// layout and the raw-response decoder.
package spu_ibr_pkg;

    localparam int DEF_TID_W  = 8;
    localparam int DEF_RSP_W  = 16;
    localparam int DEF_TILE_W = 10;
    localparam int DEF_ERR_W  = 5;

    localparam int TILE_LSB   = 0;
    localparam int STATUS_BIT = 10;
    localparam int ERR_LSB    = 11;

    typedef struct packed {
        logic [DEF_ERR_W-1:0]  err_code;
        logic                  status;
        logic [DEF_TILE_W-1:0] tile_id;
    } ibr_rsp_t;

    function automatic ibr_rsp_t decode_rsp(input logic [15:0] rsp);
        ibr_rsp_t d;
        d.tile_id  = rsp[TILE_LSB +: DEF_TILE_W];
        d.status   = rsp[STATUS_BIT];
        d.err_code = rsp[ERR_LSB +: DEF_ERR_W];
        return d;
    endfunction

endpackage

// File: rtl/spu_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module spu_rr_arb #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found_s;
    logic             hit_s;
    logic [IDX_W-1:0] pos_s;

    // scan N positions starting at ptr; the first live request wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s        = IDX_W'((int'(ptr) + k) % N);
            hit_s        = en && !found_s && req[pos_s];
            gnt[pos_s]   = gnt[pos_s] | hit_s;
            gnt_idx      = hit_s ? pos_s : gnt_idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/spu_ibr_arb.sv
// Merges NUM_SRC inbound NoC response channels into one registered,
// decoded response stream and counts error responses.
module spu_ibr_arb
    import spu_ibr_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TID_W   = DEF_TID_W,
    parameter int RSP_W   = DEF_RSP_W,
    parameter int TILE_W  = DEF_TILE_W,
    parameter int ERR_W   = DEF_ERR_W,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NUM_SRC-1:0]       src_vld,
    input  logic [NUM_SRC*TID_W-1:0] src_tid,
    input  logic [NUM_SRC*RSP_W-1:0] src_rsp,
    output logic [NUM_SRC-1:0]       src_rdy,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [IDX_W-1:0]         out_src,
    output logic [TID_W-1:0]         out_tid,
    output logic [TILE_W-1:0]        out_tile_id,
    output logic                     out_status,
    output logic [ERR_W-1:0]         out_err_code,
    output logic [CNT_W-1:0]         err_cnt,
    input  logic                     err_cnt_clr
);

    logic               free_s;
    logic               en_s;
    logic               xfer_s;
    logic [NUM_SRC-1:0] gnt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic [TID_W-1:0]   sel_tid_s;
    logic [RSP_W-1:0]   sel_rsp_s;
    ibr_rsp_t           dec_s;

    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic               vld_q,      vld_d;
    logic [IDX_W-1:0]   src_q,      src_d;
    logic [TID_W-1:0]   tid_q,      tid_d;
    logic [TILE_W-1:0]  tile_q,     tile_d;
    logic               status_q,   status_d;
    logic [ERR_W-1:0]   err_code_q, err_code_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    // the slot accepts a new response when empty or being drained this cycle
    assign free_s = !vld_q || out_rdy;
    assign en_s   = arb_en && free_s && !rst;

    spu_rr_arb #(.N(NUM_SRC)) u_rr (
        .req     (src_vld),
        .ptr     (ptr_q),
        .en      (en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign src_rdy   = gnt_s;
    assign xfer_s    = |gnt_s;
    assign sel_tid_s = src_tid[gnt_idx_s*TID_W +: TID_W];
    assign sel_rsp_s = src_rsp[gnt_idx_s*RSP_W +: RSP_W];
    assign dec_s     = decode_rsp(sel_rsp_s[15:0]);

    // next state of pointer, output register and error counter
    always_comb begin
        ptr_d      = ptr_q;
        vld_d      = vld_q;
        src_d      = src_q;
        tid_d      = tid_q;
        tile_d     = tile_q;
        status_d   = status_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        if (xfer_s) begin
            ptr_d      = (gnt_idx_s == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx_s + IDX_W'(1);
            vld_d      = 1'b1;
            src_d      = gnt_idx_s;
            tid_d      = sel_tid_s;
            tile_d     = TILE_W'(dec_s.tile_id);
            status_d   = dec_s.status;
            err_code_d = ERR_W'(dec_s.err_code);
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
        // clear wins over a same-cycle increment; the count saturates
        if (err_cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_s && dec_s.status && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            vld_q      <= 1'b0;
            src_q      <= '0;
            tid_q      <= '0;
            tile_q     <= '0;
            status_q   <= 1'b0;
            err_code_q <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_q      <= vld_d;
            src_q      <= src_d;
            tid_q      <= tid_d;
            tile_q     <= tile_d;
            status_q   <= status_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_vld      = vld_q;
    assign out_src      = src_q;
    assign out_tid      = tid_q;
    assign out_tile_id  = tile_q;
    assign out_status   = status_q;
    assign out_err_code = err_code_q;
    assign err_cnt      = cnt_q;

endmodule
